// File: rtl/intpol2_d4_pkg.sv
// Shared types and constants for the interpolator output streamer.
package intpol2_d4_pkg;

    // Entries held in the local skid buffer; also the pop credit limit.
    localparam logic [1:0] SKID_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/intpol2_d4_skid2.sv
// Two-entry skid buffer of {data,last}; entry 0 is always the head.
module intpol2_d4_skid2 #(
    parameter int DATAPATH_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic                      wr,
    input  logic [DATAPATH_WIDTH-1:0] wr_data,
    input  logic                      wr_last,
    input  logic                      rd,
    output logic [DATAPATH_WIDTH-1:0] rd_data,
    output logic                      rd_last,
    output logic                      valid,
    output logic [1:0]                cnt
);

    typedef struct packed {
        logic [DATAPATH_WIDTH-1:0] data;
        logic                      last;
    } entry_t;

    entry_t     e0_q;
    entry_t     e1_q;
    logic [1:0] cnt_q;
    entry_t     wr_entry;

    assign wr_entry = '{data: wr_data, last: wr_last};

    // Shift-register FIFO: a read moves entry 1 to the head, a write fills the first free slot.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the two data entries are reset too, so the stream outputs read 0 straight out of reset.
        if (!rstn) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments let e0 take the old e1 while e1 takes new data in the same edge.
            case ({wr, rd})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_q <= wr_entry;
                    else               e1_q <= wr_entry;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_q <= wr_entry;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= wr_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid   = (cnt_q != 2'd0);
    assign cnt     = cnt_q;
    assign rd_data = e0_q.data;
    assign rd_last = e0_q.last;

endmodule

// File: rtl/intpol2_d4_out_streamer.sv
// Drains the interpolator output FIFO onto a valid/ready stream, olen samples per run.
module intpol2_d4_out_streamer
    import intpol2_d4_pkg::*;
#(
    parameter int DATAPATH_WIDTH = 32,
    parameter int CONFIG_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      clear,
    input  logic [CONFIG_WIDTH-1:0]   olen,
    input  logic                      Empty_i,
    input  logic [DATAPATH_WIDTH-1:0] fifo_rdata_i,
    output logic                      Read_Enable,
    output logic [DATAPATH_WIDTH-1:0] m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic                      busy,
    output logic                      done
);

    localparam logic [CONFIG_WIDTH-1:0] ONE = {{(CONFIG_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [CONFIG_WIDTH-1:0] len_q;
    logic [CONFIG_WIDTH-1:0] rd_cnt_q;
    logic [CONFIG_WIDTH-1:0] out_cnt_q;
    logic                    inflight_q;
    logic                    inflight_last_q;
    logic                    done_q;

    logic [1:0]              skid_cnt;
    logic                    pop;
    logic                    pop_last;
    logic                    handshake;
    logic                    credit_ok;
    logic                    start_run;

    // Pending pops count against skid space so the buffer can never overflow.
    assign credit_ok = (skid_cnt + {1'b0, inflight_q}) < SKID_DEPTH;
    assign pop       = (state_q == ST_RUN) && !Empty_i && (rd_cnt_q < len_q) && credit_ok && !clear;
    assign pop_last  = (rd_cnt_q == (len_q - ONE));
    assign handshake = m_tvalid && m_tready;
    assign start_run = (state_q == ST_IDLE) && start && !clear;

    assign Read_Enable = pop;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = done_q;

    // Next-state logic; clear overrides every transition.
    always_comb begin
        // NOTE: defaulting state_d before the case keeps this block free of inferred latches.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (olen == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (rd_cnt_q == len_q) state_d = ST_DRAIN;
            ST_DRAIN: if (out_cnt_q == len_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    // State register and registered done pulse (high for the single DONE cycle).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Run length and pop/accept counters; a new start re-arms them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q     <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (start_run) begin
            len_q     <= olen;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (pop)       rd_cnt_q  <= rd_cnt_q + ONE;
            if (handshake) out_cnt_q <= out_cnt_q + ONE;
        end
    end

    // In-flight flag covers the FIFO's one-cycle read latency; last is fixed at pop time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else if (clear) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= pop;
            inflight_last_q <= pop && pop_last;
        end
    end

    intpol2_d4_skid2 #(
        .DATAPATH_WIDTH (DATAPATH_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (clear),
        .wr      (inflight_q),
        .wr_data (fifo_rdata_i),
        .wr_last (inflight_last_q),
        .rd      (handshake),
        .rd_data (m_tdata),
        .rd_last (m_tlast),
        .valid   (m_tvalid),
        .cnt     (skid_cnt)
    );

endmodule

// File: tb/tb_intpol2_d4_out_streamer.sv
// Scoreboard bench for the output streamer: a FIFO model feeds random samples,
// expected beats are queued at start, and a monitor checks every handshake.
module tb_intpol2_d4_out_streamer;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          clear;
    logic [CW-1:0] olen;
    logic          Empty_i;
    logic [DW-1:0] fifo_rdata_i;
    logic          Read_Enable;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          busy;
    logic          done;

    intpol2_d4_out_streamer #(
        .DATAPATH_WIDTH (DW),
        .CONFIG_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .clear        (clear),
        .olen         (olen),
        .Empty_i      (Empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .Read_Enable  (Read_Enable),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic [DW-1:0] src_q[$];
    beat_t         exp_q[$];
    beat_t         mon_e;

    int n_vec = 0;
    int n_fail = 0;
    int beats_seen = 0;
    int pops_seen = 0;
    int outstanding = 0;
    int done_cnt = 0;
    int cur_len = 0;
    bit expect_done = 1'b0;
    bit in_reset = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Source FIFO model: data appears one cycle after a pop.
    always @(posedge clk) begin
        if (rstn && Read_Enable && src_q.size() > 0) begin
            fifo_rdata_i <= src_q[0];
            src_q.pop_front();
        end
    end

    // Monitor: sample away from the active edge and score every handshake.
    always @(negedge clk) begin
        if (rstn && !in_reset) begin
            if (Read_Enable) begin
                pops_seen++;
                check("pop_while_empty", Empty_i, 0);
                check("pop_beyond_olen", pops_seen <= cur_len, 1);
            end
            outstanding += int'(Read_Enable) - int'(m_tvalid && m_tready);
            if (Read_Enable) check("outstanding_le2", outstanding <= 2, 1);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", m_tdata, mon_e.data);
                    check("beat_last", m_tlast, mon_e.last);
                end
                beats_seen++;
            end
            if (done) begin
                done_cnt++;
                check("done_expected", expect_done, 1);
                check("done_after_all_beats", exp_q.size(), 0);
            end
            if (cur_len == 0 && busy)     check("busy_zero_len", busy, 0);
            if (cur_len == 0 && m_tvalid) check("tvalid_zero_len", m_tvalid, 0);
        end
    end

    // Queue the reference stream (first n source words, last on word n-1) and pulse start.
    task automatic start_run(input int n, input bit exp_done);
        beat_t b;
        while (src_q.size() < n + 8) src_q.push_back($urandom);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b.data = src_q[i];
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
        cur_len     = n;
        pops_seen   = 0;
        beats_seen  = 0;
        done_cnt    = 0;
        expect_done = exp_done;
        olen        = CW'(n);
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // One complete run. ready_mode: 0 always, 1 random, 2 five-cycle stall after beat 1.
    // empty_mode: 0 never, 1 alternate cycles, 2 random.
    task automatic run(input int n, input int ready_mode, input int empty_mode, input bit check_lat);
        int cyc = 0;
        int stall = 0;
        m_tready = 1'b1;
        Empty_i  = 1'b0;
        start_run(n, 1'b1);
        if (check_lat) begin
            check("lat_cycle0", m_tvalid, 0);
            @(posedge clk);
            #1 check("lat_cycle1", m_tvalid, 0);
            @(posedge clk);
            #1 check("lat_cycle2", m_tvalid, 1);
        end
        while (done_cnt == 0 && cyc < 2000) begin
            case (ready_mode)
                1: m_tready = 1'($urandom_range(0, 1));
                2: begin
                    if (beats_seen >= 1 && stall < 5) begin
                        m_tready = 1'b0;
                        stall++;
                    end else begin
                        m_tready = 1'b1;
                    end
                end
                default: m_tready = 1'b1;
            endcase
            case (empty_mode)
                1: Empty_i = 1'(cyc % 2);
                2: Empty_i = ($urandom_range(0, 2) == 0);
                default: Empty_i = 1'b0;
            endcase
            @(posedge clk);
            #1 cyc++;
        end
        check("run_no_timeout", done_cnt > 0, 1);
        m_tready = 1'b1;
        Empty_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done_single_pulse", done_cnt, 1);
        check("idle_after_run", busy, 0);
        check("beats_per_run", beats_seen, n);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Wait (bounded) until the monitor has counted at least n beats.
    task automatic wait_beats(input int n, input string name);
        int cyc = 0;
        while (beats_seen < n && cyc < 500) begin
            @(posedge clk);
            #1 cyc++;
        end
        check(name, beats_seen >= n, 1);
    endtask

    initial begin
        rstn     = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        olen     = '0;
        Empty_i  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tvalid", m_tvalid, 0);
        check("reset_tdata", m_tdata, 0);
        check("reset_read_enable", Read_Enable, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rstn     = 1'b1;
        in_reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic run with latency check, then zero-length run.
        run(8, 0, 0, 1'b1);
        run(0, 0, 0, 1'b0);

        // Back-pressure stall and FIFO empty toggling.
        run(6, 2, 0, 1'b0);
        run(4, 0, 1, 1'b0);

        // Clear after three beats: no done, then a fresh short run.
        m_tready = 1'b1;
        Empty_i  = 1'b0;
        start_run(10, 1'b0);
        wait_beats(3, "clear_reach_beat3");
        m_tready    = 1'b0;
        clear       = 1'b1;
        exp_q.delete();
        outstanding = 0;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_tvalid", m_tvalid, 0);
        check("clear_read_enable", Read_Enable, 0);
        m_tready = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("clear_no_done", done_cnt, 0);
        run(2, 0, 0, 1'b0);

        // Asynchronous reset mid-run, then a normal run.
        m_tready = 1'b1;
        Empty_i  = 1'b0;
        start_run(20, 1'b0);
        wait_beats(3, "reset_reach_beat3");
        #2;
        in_reset = 1'b1;
        rstn     = 1'b0;
        #1;
        check("async_rst_tvalid", m_tvalid, 0);
        check("async_rst_tlast", m_tlast, 0);
        check("async_rst_tdata", m_tdata, 0);
        check("async_rst_read_enable", Read_Enable, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        exp_q.delete();
        outstanding = 0;
        @(posedge clk);
        #1 rstn = 1'b1;
        in_reset = 1'b0;
        @(posedge clk);
        #1 check("post_reset_idle", busy, 0);
        run(5, 0, 0, 1'b1);

        // Randomized runs with random back-pressure and FIFO gaps.
        for (int k = 0; k < 6; k++) begin
            run(int'($urandom_range(1, 12)), 1, 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
